fib_seq_engine: RTL and testbench

Parametrised successor to the fixed-width Fibonacci top level. It computes the n-th term of a generalised second-order recurrence F(i) = A·F(i-1) + B·F(i-2), with programmable seeds and coefficients. It generates one term per clock under a start/ready handshake. Overflow is flagged, not hidden. It sits in the same datapath slot as the fixed Fibonacci block; with A=B=1 and seeds 0/1 it produces the classic sequence.

---
 rtl/fib_seq_engine.sv | 117 +++++++++++
 tb/tb_fib_seq_engine.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/fib_seq_engine.sv
// Generalised second-order recurrence engine: F(i) = A*F(i-1) + B*F(i-2).
// One term per clock; start/ready handshake with a sticky per-run overflow flag.
module fib_seq_engine #(
  parameter int DW = 16,
  parameter int NW = 6,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [NW-1:0] n,
  input  logic [CW-1:0] coef_a,
  input  logic [CW-1:0] coef_b,
  input  logic [DW-1:0] seed0,
  input  logic [DW-1:0] seed1,
  output logic [DW-1:0] out,
  output logic          outReady,
  output logic          busy,
  output logic          ovf
);

  localparam int FW = DW + CW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] a_reg, b_reg;
  logic [DW-1:0] pp_reg, p_reg, out_reg;
  logic [NW-1:0] cnt_reg;
  logic          ovf_reg;

  logic          accept;
  logic          last_term;
  logic [FW-1:0] full;
  logic [DW-1:0] nxt;
  logic          term_ovf;

  // start is only honoured outside CALC; requests during a run are dropped
  assign accept    = start && (state_reg != CALC);
  assign last_term = (cnt_reg == NW'(2));

  always_comb begin
    full     = FW'(a_reg) * FW'(p_reg) + FW'(b_reg) * FW'(pp_reg);
    nxt      = full[DW-1:0];
    term_ovf = |full[FW-1:DW];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          state_next = (n < NW'(2)) ? DONE : CALC;
        end
      end
      CALC: begin
        if (last_term) begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_reg == CALC);
    outReady = (state_reg == DONE);
    out      = out_reg;
    ovf      = ovf_reg;
  end

  // Datapath: cnt counts down from n; the edge with cnt==2 produces F(n)
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg   <= '0;
      b_reg   <= '0;
      pp_reg  <= '0;
      p_reg   <= '0;
      cnt_reg <= '0;
      out_reg <= '0;
      ovf_reg <= 1'b0;
    end else if (accept) begin
      a_reg   <= coef_a;
      b_reg   <= coef_b;
      pp_reg  <= seed0;
      p_reg   <= seed1;
      cnt_reg <= n;
      ovf_reg <= 1'b0;
      if (n == NW'(0)) begin
        out_reg <= seed0;
      end else if (n == NW'(1)) begin
        out_reg <= seed1;
      end
    end else if (state_reg == CALC) begin
      pp_reg  <= p_reg;
      p_reg   <= nxt;
      cnt_reg <= cnt_reg - NW'(1);
      ovf_reg <= ovf_reg | term_ovf;
      if (last_term) begin
        out_reg <= nxt;
      end
    end
  end

endmodule

// File: tb/tb_fib_seq_engine.sv
// Directed, table-driven bench for fib_seq_engine with hand-computed results,
// plus sequences for mid-run start pulses and mid-run reset.
module tb_fib_seq_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [5:0]  n;
  logic [3:0]  coef_a;
  logic [3:0]  coef_b;
  logic [15:0] seed0;
  logic [15:0] seed1;
  logic [15:0] out;
  logic        outReady;
  logic        busy;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [5:0]  n;
    logic [3:0]  a;
    logic [3:0]  b;
    logic [15:0] s0;
    logic [15:0] s1;
    logic [15:0] exp_out;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs [0:11];

  fib_seq_engine #(.DW(16), .NW(6), .CW(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .n        (n),
    .coef_a   (coef_a),
    .coef_b   (coef_b),
    .seed0    (seed0),
    .seed1    (seed1),
    .out      (out),
    .outReady (outReady),
    .busy     (busy),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Issue one request, scramble the inputs after acceptance, and wait for outReady.
  task automatic run_vec(input vec_t v, input bit noise, input string tag);
    int edges;
    int busy_cnt;
    int exp_edges;
    @(negedge clk);
    n      = v.n;
    coef_a = v.a;
    coef_b = v.b;
    seed0  = v.s0;
    seed1  = v.s1;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    n      = 6'($urandom);
    coef_a = 4'($urandom);
    coef_b = 4'($urandom);
    seed0  = 16'($urandom);
    seed1  = 16'($urandom);
    edges    = 0;
    busy_cnt = 0;
    while (!outReady && edges < 100) begin
      if (busy) busy_cnt++;
      if (noise && edges < 4) begin
        start = 1'b1;
        n     = 6'($urandom_range(0, 3));
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      edges++;
    end
    start = 1'b0;
    exp_edges = (v.n <= 6'd1) ? 0 : int'(v.n) - 1;
    $display("run %s n=%0d A=%0d B=%0d out=%0d ovf=%0d edges=%0d busy=%0d",
             tag, v.n, v.a, v.b, out, ovf, edges, busy_cnt);
    check({tag, " out"},     32'(out),      32'(v.exp_out));
    check({tag, " ovf"},     32'(ovf),      32'(v.exp_ovf));
    check({tag, " latency"}, 32'(edges),    32'(exp_edges));
    check({tag, " busy"},    32'(busy_cnt), 32'(exp_edges));
    check({tag, " busy_done"}, 32'(busy),   32'd0);
  endtask

  initial begin
    vec_t v;
    vecs[0]  = '{6'd10, 4'd1,  4'd1, 16'd0,      16'd1,      16'd55,    1'b0};
    vecs[1]  = '{6'd8,  4'd2,  4'd1, 16'd0,      16'd1,      16'd408,   1'b0};
    vecs[2]  = '{6'd0,  4'd2,  4'd1, 16'd0,      16'd1,      16'd0,     1'b0};
    vecs[3]  = '{6'd1,  4'd2,  4'd1, 16'd0,      16'd1,      16'd1,     1'b0};
    vecs[4]  = '{6'd24, 4'd1,  4'd1, 16'd0,      16'd1,      16'd46368, 1'b0};
    vecs[5]  = '{6'd25, 4'd1,  4'd1, 16'd0,      16'd1,      16'd9489,  1'b1};
    vecs[6]  = '{6'd5,  4'd1,  4'd1, 16'd0,      16'd1,      16'd5,     1'b0};
    vecs[7]  = '{6'd2,  4'd3,  4'd2, 16'd5,      16'd7,      16'd31,    1'b0};
    vecs[8]  = '{6'd1,  4'd1,  4'd1, 16'hFFFF,   16'hFFFF,   16'hFFFF,  1'b0};
    vecs[9]  = '{6'd63, 4'd1,  4'd0, 16'd0,      16'd1234,   16'd1234,  1'b0};
    vecs[10] = '{6'd3,  4'd15, 4'd15, 16'hFFFF,  16'hFFFF,   16'd65071, 1'b1};
    vecs[11] = '{6'd4,  4'd0,  4'd1, 16'd5,      16'd9,      16'd5,     1'b0};

    rst    = 1'b1;
    start  = 1'b0;
    n      = '0;
    coef_a = '0;
    coef_b = '0;
    seed0  = '0;
    seed1  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset out",      32'(out),      32'd0);
    check("reset outReady", 32'(outReady), 32'd0);
    check("reset busy",     32'(busy),     32'd0);
    check("reset ovf",      32'(ovf),      32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      run_vec(vecs[i], 1'b0, $sformatf("vec%0d", i));
    end

    // Start pulses during CALC must be ignored
    run_vec(vecs[0], 1'b1, "noise");

    // Reset three edges into an n=20 run, with start asserted alongside it
    @(negedge clk);
    n = 6'd20; coef_a = 4'd1; coef_b = 4'd1; seed0 = 16'd0; seed1 = 16'd1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("midrun busy", 32'(busy), 32'd1);
    @(negedge clk);
    rst = 1'b1; start = 1'b1; n = 6'd3;
    @(posedge clk);
    #1;
    $display("reset mid-run out=%0d outReady=%0d busy=%0d ovf=%0d", out, outReady, busy, ovf);
    check("abort out",      32'(out),      32'd0);
    check("abort outReady", 32'(outReady), 32'd0);
    check("abort busy",     32'(busy),     32'd0);
    check("abort ovf",      32'(ovf),      32'd0);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    @(posedge clk);
    #1;
    check("idle outReady", 32'(outReady), 32'd0);
    check("idle busy",     32'(busy),     32'd0);
    v = '{6'd6, 4'd1, 4'd1, 16'd0, 16'd1, 16'd8, 1'b0};
    run_vec(v, 1'b0, "post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
